// File: rtl/ann_pkg.sv
// rtl/ann_pkg.sv - shared types and width helpers for the ANN output stages
package ann_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } argmax_state_t;

  // Layer outputs carry 8 guard bits above the producing layer's data width.
  function automatic int elem_width(input int layer_data_width);
    return layer_data_width + 8;
  endfunction

  function automatic int idx_width(input int layer_num);
    return (layer_num <= 1) ? 1 : $clog2(layer_num);
  endfunction

endpackage

// File: rtl/layer_argmax.sv
// rtl/layer_argmax.sv - sequential argmax over a snapshotted layer output vector
module layer_argmax
  import ann_pkg::*;
#(
  parameter int LAYER_DATA_WIDTH = 16,
  parameter int LAYER_NUM        = 10,
  localparam int IDX_W           = idx_width(LAYER_NUM),
  localparam int EW              = elem_width(LAYER_DATA_WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [EW-1:0] data_in [0:LAYER_NUM-1],
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [IDX_W-1:0]     class_idx,
  output logic signed [EW-1:0] max_val,
  output logic                 tie
);

  localparam logic SINGLE = (LAYER_NUM == 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LAYER_NUM - 1);

  argmax_state_t state, state_nxt;

  logic signed [EW-1:0] snap [0:LAYER_NUM-1];
  logic signed [EW-1:0] best_val;
  logic [IDX_W-1:0]     best_idx;
  logic                 best_tie;
  logic [IDX_W-1:0]     cnt;

  logic                 accept;
  logic                 scan_last;
  logic signed [EW-1:0] cur;
  logic signed [EW-1:0] nxt_val;
  logic [IDX_W-1:0]     nxt_idx;
  logic                 nxt_tie;

  assign accept    = (state == IDLE) && in_valid && !clear;
  assign scan_last = (cnt == LAST_IDX);
  assign cur       = snap[cnt];

  // Strictly-greater replaces the best, so on equality the lowest index is kept.
  always_comb begin
    nxt_val = best_val;
    nxt_idx = best_idx;
    nxt_tie = best_tie;
    if (cur > best_val) begin
      nxt_val = cur;
      nxt_idx = cnt;
      nxt_tie = 1'b0;
    end else if (cur == best_val) begin
      nxt_tie = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = SINGLE ? DONE : SCAN;
      end
      SCAN: begin
        if (scan_last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (clear) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAYER_NUM; i++) snap[i] <= '0;
      best_val  <= '0;
      best_idx  <= '0;
      best_tie  <= 1'b0;
      cnt       <= '0;
      class_idx <= '0;
      max_val   <= '0;
      tie       <= 1'b0;
    end else if (clear) begin
      cnt <= '0;
    end else if (accept) begin
      for (int i = 0; i < LAYER_NUM; i++) snap[i] <= data_in[i];
      best_val <= data_in[0];
      best_idx <= '0;
      best_tie <= 1'b0;
      cnt      <= IDX_W'(1);
      if (SINGLE) begin
        class_idx <= '0;
        max_val   <= data_in[0];
        tie       <= 1'b0;
      end
    end else if (state == SCAN) begin
      best_val <= nxt_val;
      best_idx <= nxt_idx;
      best_tie <= nxt_tie;
      cnt      <= cnt + IDX_W'(1);
      if (scan_last) begin
        class_idx <= nxt_idx;
        max_val   <= nxt_val;
        tie       <= nxt_tie;
      end
    end
  end

endmodule

// File: tb/tb_layer_argmax.sv
// tb/tb_layer_argmax.sv - directed vector bench for layer_argmax
module tb_layer_argmax;

  localparam int N    = 10;
  localparam int EW   = 24;
  localparam int MINV = -8388608;
  localparam int MAXV = 8388607;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  logic in_valid, in_ready, out_valid, out_ready, tie;
  logic signed [EW-1:0] data_in [0:N-1];
  logic [3:0] class_idx;
  logic signed [EW-1:0] max_val;

  logic in_valid1, in_ready1, out_valid1, out_ready1, tie1;
  logic signed [EW-1:0] data_in1 [0:0];
  logic [0:0] class_idx1;
  logic signed [EW-1:0] max_val1;

  always #5 clk = ~clk;

  layer_argmax #(.LAYER_DATA_WIDTH(16), .LAYER_NUM(N)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_ready(in_ready), .data_in(data_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .class_idx(class_idx), .max_val(max_val), .tie(tie)
  );

  layer_argmax #(.LAYER_DATA_WIDTH(16), .LAYER_NUM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid1), .in_ready(in_ready1), .data_in(data_in1),
    .out_valid(out_valid1), .out_ready(out_ready1),
    .class_idx(class_idx1), .max_val(max_val1), .tie(tie1)
  );

  typedef struct {
    int v [N];
    int ei;
    int ev;
    int et;
  } vec_t;

  vec_t vecs [8];
  int total = 0;
  int bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic load(input int k);
    for (int j = 0; j < N; j++) data_in[j] = EW'(vecs[k].v[j]);
  endtask

  // Called #1 after the accept edge: scrambles the source, waits for the result, checks it.
  task automatic finish_vec(input int k);
    int lat;
    for (int j = 0; j < N; j++) data_in[j] = EW'(MAXV);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, N - 1);
    chk("class_idx", class_idx, vecs[k].ei);
    chk("max_val", max_val, vecs[k].ev);
    chk("tie", tie, vecs[k].et);
    @(posedge clk); #1;
    chk("out_valid_one_cycle", out_valid, 0);
    chk("in_ready_after_hs", in_ready, 1);
  endtask

  task automatic run_vec(input int k);
    load(k);
    in_valid = 1'b1;
    chk("in_ready_idle", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("in_ready_scan", in_ready, 0);
    finish_vec(k);
  endtask

  task automatic no_result(input string nm, input int cycles);
    int seen;
    seen = 0;
    for (int c = 0; c < cycles; c++) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    chk(nm, seen, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0].v = '{3, -5, 7, 2, 9, 1, 0, -1, 4, 6};
    vecs[0].ei = 4; vecs[0].ev = 9; vecs[0].et = 0;
    vecs[1].v = '{5, 8, -2, 8, 8, 0, 0, 0, 0, 0};
    vecs[1].ei = 1; vecs[1].ev = 8; vecs[1].et = 1;
    vecs[2].v = '{8, 9, 8, 0, 0, 0, 0, 0, 0, 0};
    vecs[2].ei = 1; vecs[2].ev = 9; vecs[2].et = 0;
    vecs[3].v = '{MINV, MINV, MINV, MINV, MINV, MINV, MINV, MINV, MINV, -1};
    vecs[3].ei = 9; vecs[3].ev = -1; vecs[3].et = 0;
    vecs[4].v = '{MINV, MINV, MINV, MINV, MINV, MINV, MINV, MINV, MINV, MINV};
    vecs[4].ei = 0; vecs[4].ev = MINV; vecs[4].et = 1;
    vecs[5].v = '{MINV, -3, MINV, 100, MINV, MAXV, -1, MINV, 0, MINV};
    vecs[5].ei = 5; vecs[5].ev = MAXV; vecs[5].et = 0;
    vecs[6].v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    vecs[6].ei = 0; vecs[6].ev = 0; vecs[6].et = 1;
    vecs[7].v = '{MAXV, 5, MINV, -7, 0, 1, 2, 3, 4, MAXV};
    vecs[7].ei = 0; vecs[7].ev = MAXV; vecs[7].et = 1;

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_valid1 = 1'b0; out_ready1 = 1'b1; data_in1[0] = '0;
    for (int j = 0; j < N; j++) data_in[j] = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_class_idx", class_idx, 0);
    chk("rst_max_val", max_val, 0);
    chk("rst_tie", tie, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int k = 0; k < 8; k++) run_vec(k);

    // Backpressure: result held for 5 cycles while a new request waits.
    out_ready = 1'b0;
    load(0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int j = 0; j < N; j++) data_in[j] = EW'(MAXV);
    for (int c = 0; c < 40 && !out_valid; c++) begin
      @(posedge clk); #1;
    end
    chk("bp_out_valid", out_valid, 1);
    load(1);
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_idx", class_idx, 4);
      chk("bp_hold_val", max_val, 9);
      chk("bp_hold_tie", tie, 0);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_valid", out_valid, 0);
    chk("bp_release_ready", in_ready, 1);
    chk("bp_idle_hold_idx", class_idx, 4);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_second_accept", in_ready, 0);
    finish_vec(1);

    // clear on the 4th SCAN edge
    load(0);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    chk("clr_scan_in_ready", in_ready, 1);
    chk("clr_scan_out_valid", out_valid, 0);
    chk("clr_keeps_max_val", max_val, 8);
    no_result("clr_scan_no_result", 12);

    // clear together with in_valid in IDLE
    load(0);
    in_valid = 1'b1;
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    in_valid = 1'b0;
    chk("clr_idle_not_accepted", in_ready, 1);
    no_result("clr_idle_no_result", 12);
    run_vec(0);

    // asynchronous reset between edges, mid-SCAN
    load(2);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_in_ready", in_ready, 1);
    chk("arst_out_valid", out_valid, 0);
    chk("arst_class_idx", class_idx, 0);
    chk("arst_max_val", max_val, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    no_result("arst_no_result", 12);
    run_vec(2);

    // LAYER_NUM == 1 instance
    data_in1[0] = -24'sd7;
    in_valid1 = 1'b1;
    chk("n1_in_ready", in_ready1, 1);
    @(posedge clk); #1;
    in_valid1 = 1'b0;
    data_in1[0] = 24'sd100;
    chk("n1_out_valid", out_valid1, 1);
    chk("n1_class_idx", class_idx1, 0);
    chk("n1_max_val", max_val1, -7);
    chk("n1_tie", tie1, 0);
    @(posedge clk); #1;
    chk("n1_out_valid_drop", out_valid1, 0);
    chk("n1_in_ready_back", in_ready1, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer_argmax.md
Name: layer_argmax

Overview:
- Downstream stage of the output layer. Takes the parallel vector of signed neuron outputs and finds the index of the largest value.
- Scans one element per clock, which keeps a single comparator regardless of LAYER_NUM.
- Presents class index, winning value and a tie flag on a valid/ready output handshake to the classifier result logic.

Parameters:
- LAYER_DATA_WIDTH, 16, data width of the producing layer; element width is LAYER_DATA_WIDTH+8.
- LAYER_NUM, 10, number of elements (neurons) in the vector; must be >= 1.
- IDX_W (localparam), max(1, $clog2(LAYER_NUM)), width of the index.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- clear  in  1  synchronous abort, returns to IDLE.
- in_valid  in  1  data_in holds a complete layer result.
- in_ready  out  1  block can accept a vector.
- data_in  in  signed [LAYER_DATA_WIDTH+7:0] x [0:LAYER_NUM-1]  layer outputs.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- class_idx  out  IDX_W  index of the maximum.
- max_val  out  signed [LAYER_DATA_WIDTH+7:0]  value at class_idx.
- tie  out  1  another element equals max_val.

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset state: state=IDLE, in_ready=1, out_valid=0, class_idx=0, max_val=0, tie=0, cnt=0, snapshot array=0.
- States:
  - IDLE: in_ready=1.
  - SCAN: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1.
- Accept: IDLE with in_valid=1 at an edge.
  - Snapshot all of data_in; the source may change data_in afterwards.
  - best_val<=data_in[0], best_idx<=0, tie<=0, cnt<=1.
  - Next state is SCAN, or DONE directly if LAYER_NUM==1.
- SCAN, each edge:
  - Compare snap[cnt] against best_val as signed values.
  - Strictly greater: best_val/best_idx<=snap[cnt], cnt; tie<=0.
  - Equal: tie<=1, best unchanged, so the lowest index wins.
  - Less: no change.
  - cnt<=cnt+1; after processing cnt==LAYER_NUM-1, go to DONE.
- Latency: out_valid rises exactly LAYER_NUM-1 edges after the accept edge.
- Throughput: one vector per LAYER_NUM+1 cycles minimum, with out_ready tied high.
- DONE:
  - class_idx, max_val and tie are held stable while out_valid=1 and out_ready=0.
  - out_valid&&out_ready at an edge: go to IDLE; out_valid=0 and in_ready=1 the next cycle.
  - A new vector is never accepted in the same cycle as the output handshake.
- Output updates: class_idx, max_val and tie are registered and change only on the SCAN->DONE / accept->DONE transition. They hold their last values while in IDLE and SCAN.
- clear:
  - Synchronous; has priority over all handshakes in every state.
  - Next state IDLE, out_valid=0, cnt=0. Outputs keep their last values.
  - A simultaneous in_valid is not accepted.
- rst_n asserted mid-SCAN or in DONE: immediate return to reset state; any pending result is lost.
- in_valid while not IDLE: ignored. The producer must hold in_valid until in_ready.
- Arithmetic: two's-complement compare only; no saturation, no width change.
- Extreme values: min-negative and max-positive are handled correctly.

Decomposition:
- Shared package ann_pkg:
  - state enum argmax_state_t {IDLE, SCAN, DONE}.
  - Function for the element width (LAYER_DATA_WIDTH+8), shared with layer/neuron.
  - Helper for the index width, handling the LAYER_NUM==1 minimum of 1.
- No sub-module: comparator, counter and FSM live in one module.

Test Plan:
- LAYER_NUM=10, data_in={3,-5,7,2,9,1,0,-1,4,6}, out_ready=1 -> class_idx=4, max_val=9, tie=0; out_valid 9 edges after accept, high one cycle.
- Tie: {5,8,-2,8,8,...,0} -> class_idx=1, max_val=8, tie=1. Then {8,9,8,...} -> class_idx=1, tie=0 (tie cleared by a later strictly greater value).
- All negative incl. min (-2^(W-1)) and {-2^(W-1)...,-1 at idx 9} -> class_idx=9, max_val=-1. Also change data_in during SCAN -> result unaffected.
- Backpressure: out_ready=0 for 5 cycles in DONE -> outputs stable, in_ready=0, a new in_valid is ignored. Release -> IDLE next cycle, second vector processed correctly.
- clear asserted at 4th SCAN cycle, and asserted together with in_valid in IDLE -> IDLE, no out_valid, vector not accepted. A following vector gives the correct result.
- rst_n pulsed asynchronously mid-SCAN (between edges) -> out_valid=0, in_ready=1 immediately. LAYER_NUM=1 build: out_valid on the edge after accept, class_idx=0.
